// File: rtl/text_console_writer.sv
// text_console_writer
// Turns a host byte stream into character/attribute writes for the dual-port
// text RAM read by the HDMI console renderer. Owns the cursor, interprets
// CR/LF/BS/FF, and scrolls by bumping the row offset the renderer applies,
// then blanking the newly exposed bottom row.
//
// Ports:
//   CLOCK_CORE    - single clock
//   RESET_N       - asynchronous active-low reset
//   CHAR_VALID    - host byte present on CHAR_DATA
//   CHAR_DATA     - character or control code
//   CHAR_READY    - byte accepted on an edge with CHAR_VALID & CHAR_READY
//   ATTR_WE       - load ATTR_DATA into the attribute register
//   ATTR_DATA     - new attribute
//   WR_EN         - one-cycle RAM write strobe
//   WR_ADDRESS    - {physical_row[5:0], col[6:0]}
//   WR_CHAR_DATA  - character written
//   WR_ATTR_DATA  - attribute written
//   ROW_OFFSET    - hardware scroll offset for the renderer, [7:6] always 0
//   CURSOR_COL    - logical cursor column
//   CURSOR_ROW    - logical cursor row (0 = top visible row)
module text_console_writer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
  input  logic        CLOCK_CORE,
  input  logic        RESET_N,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  input  logic        ATTR_WE,
  input  logic [7:0]  ATTR_DATA,
  output logic        WR_EN,
  output logic [12:0] WR_ADDRESS,
  output logic [7:0]  WR_CHAR_DATA,
  output logic [7:0]  WR_ATTR_DATA,
  output logic [7:0]  ROW_OFFSET,
  output logic [6:0]  CURSOR_COL,
  output logic [5:0]  CURSOR_ROW
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCROLL_CLR = 2'd1,
    CLS_CLR    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  offset_q, offset_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  clr_attr_q, clr_attr_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [5:0]  clr_row_q, clr_row_d;
  logic        wr_en_q, wr_en_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_char_q, wr_char_d;
  logic [7:0]  wr_attr_q, wr_attr_d;

  logic        accept;
  logic        do_newline;
  logic [5:0]  cur_phys_row;
  logic [5:0]  clr_phys_row;

  // 6-bit sums wrap naturally, giving the mod-64 logical-to-physical mapping.
  assign cur_phys_row = row_q + offset_q;
  assign clr_phys_row = clr_row_q + offset_q;

  assign accept = CHAR_VALID && CHAR_READY;

  // State and datapath registers.
  always_ff @(posedge CLOCK_CORE or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      offset_q   <= '0;
      attr_q     <= DEFAULT_ATTR;
      clr_attr_q <= DEFAULT_ATTR;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_char_q  <= '0;
      wr_attr_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      offset_q   <= offset_d;
      attr_q     <= attr_d;
      clr_attr_q <= clr_attr_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_char_q  <= wr_char_d;
      wr_attr_q  <= wr_attr_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    offset_d   = offset_q;
    clr_attr_d = clr_attr_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_char_d  = wr_char_q;
    wr_attr_d  = wr_attr_q;
    do_newline = 1'b0;
    // The attribute register is updated in every state; chars and clears
    // below sample attr_q, so a coincident update only affects later bytes.
    attr_d     = ATTR_WE ? ATTR_DATA : attr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (CHAR_DATA)
            CH_CR: col_d = '0;
            CH_LF: do_newline = 1'b1;
            CH_BS: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
            CH_FF: begin
              clr_attr_d = attr_q;
              clr_col_d  = '0;
              clr_row_d  = '0;
              state_d    = CLS_CLR;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = {cur_phys_row, col_q};
              wr_char_d = CHAR_DATA;
              wr_attr_d = attr_q;
              if (col_q < LAST_COL) begin
                col_d = col_q + 7'd1;
              end else begin
                col_d      = '0;
                do_newline = 1'b1;
              end
            end
          endcase

          // At the bottom row a newline scrolls: the offset moves now so the
          // clear below already addresses the freshly exposed physical row.
          if (do_newline) begin
            if (row_q < LAST_ROW) begin
              row_d = row_q + 6'd1;
            end else begin
              offset_d   = offset_q + 6'd1;
              clr_attr_d = attr_q;
              clr_col_d  = '0;
              clr_row_d  = LAST_ROW;
              state_d    = SCROLL_CLR;
            end
          end
        end
      end

      SCROLL_CLR, CLS_CLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {clr_phys_row, clr_col_q};
        wr_char_d = CH_SPACE;
        wr_attr_d = clr_attr_q;
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          if (state_q == SCROLL_CLR) begin
            state_d = IDLE;
          end else if (clr_row_q == LAST_ROW) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
          end else begin
            clr_row_d = clr_row_q + 6'd1;
          end
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output decode: only IDLE takes host bytes.
  always_comb begin
    CHAR_READY = (state_q == IDLE);
  end

  assign WR_EN        = wr_en_q;
  assign WR_ADDRESS   = wr_addr_q;
  assign WR_CHAR_DATA = wr_char_q;
  assign WR_ATTR_DATA = wr_attr_q;
  assign ROW_OFFSET   = {2'b00, offset_q};
  assign CURSOR_COL   = col_q;
  assign CURSOR_ROW   = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a cell-level console model pushes
// expected RAM writes into a queue; a monitor pops on every WR_EN cycle.
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [7:0] DEF_ATTR = 8'h0F;

  logic        CLOCK_CORE = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        CHAR_VALID = 1'b0;
  logic [7:0]  CHAR_DATA  = 8'h00;
  logic        CHAR_READY;
  logic        ATTR_WE    = 1'b0;
  logic [7:0]  ATTR_DATA  = 8'h00;
  logic        WR_EN;
  logic [12:0] WR_ADDRESS;
  logic [7:0]  WR_CHAR_DATA;
  logic [7:0]  WR_ATTR_DATA;
  logic [7:0]  ROW_OFFSET;
  logic [6:0]  CURSOR_COL;
  logic [5:0]  CURSOR_ROW;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .DEFAULT_ATTR(DEF_ATTR)) dut (
    .CLOCK_CORE  (CLOCK_CORE),
    .RESET_N     (RESET_N),
    .CHAR_VALID  (CHAR_VALID),
    .CHAR_DATA   (CHAR_DATA),
    .CHAR_READY  (CHAR_READY),
    .ATTR_WE     (ATTR_WE),
    .ATTR_DATA   (ATTR_DATA),
    .WR_EN       (WR_EN),
    .WR_ADDRESS  (WR_ADDRESS),
    .WR_CHAR_DATA(WR_CHAR_DATA),
    .WR_ATTR_DATA(WR_ATTR_DATA),
    .ROW_OFFSET  (ROW_OFFSET),
    .CURSOR_COL  (CURSOR_COL),
    .CURSOR_ROW  (CURSOR_ROW)
  );

  always #5 CLOCK_CORE = ~CLOCK_CORE;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  ch;
    logic [7:0]  at;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Behavioural console model: cursor, scroll offset, current attribute.
  int         m_col, m_row, m_off;
  logic [7:0] m_attr;

  function automatic wr_t make_wr(input int lrow, input int col, input logic [7:0] ch,
                                  input logic [7:0] at);
    wr_t w;
    int  phys;
    phys   = (lrow + m_off) % 64;
    w.addr = 13'(phys * 128 + col);
    w.ch   = ch;
    w.at   = at;
    return w;
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_off = 0; m_attr = DEF_ATTR;
  endtask

  task automatic model_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      m_off = (m_off + 1) % 64;
      for (int c = 0; c < COLS; c++) exp_q.push_back(make_wr(ROWS - 1, c, 8'h20, m_attr));
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (b)
      8'h0D: m_col = 0;
      8'h0A: model_newline();
      8'h08: if (m_col > 0) m_col--;
      8'h0C: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) exp_q.push_back(make_wr(r, c, 8'h20, m_attr));
        m_col = 0; m_row = 0;
      end
      default: begin
        exp_q.push_back(make_wr(m_row, m_col, b, m_attr));
        if (m_col < COLS - 1) m_col++;
        else begin
          m_col = 0;
          model_newline();
        end
      end
    endcase
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest outstanding expectation.
  always @(negedge CLOCK_CORE) begin
    if (RESET_N && WR_EN) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h ch 0x%0h at 0x%0h, expected none",
                 WR_ADDRESS, WR_CHAR_DATA, WR_ATTR_DATA);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({WR_ADDRESS, WR_CHAR_DATA, WR_ATTR_DATA} !== e) begin
          n_bad++;
          $display("[TB] FAIL ram_write: got addr 0x%0h ch 0x%0h at 0x%0h, expected addr 0x%0h ch 0x%0h at 0x%0h",
                   WR_ADDRESS, WR_CHAR_DATA, WR_ATTR_DATA, e.addr, e.ch, e.at);
        end
      end
    end
  end

  // Send one byte, optionally with a coincident attribute load. Cursor and
  // offset are checked against the model whenever the writer is ready.
  task automatic apply_stimulus(input logic [7:0] b, input logic we, input logic [7:0] av);
    int guard = 0;
    @(negedge CLOCK_CORE);
    while (!CHAR_READY && guard < 5000) begin
      @(negedge CLOCK_CORE);
      guard++;
    end
    if (!CHAR_READY) begin
      check_output("ready_timeout", {31'd0, CHAR_READY}, 32'd1);
      return;
    end
    check_output("cursor_col", {25'd0, CURSOR_COL}, 32'(m_col));
    check_output("cursor_row", {26'd0, CURSOR_ROW}, 32'(m_row));
    check_output("row_offset", {24'd0, ROW_OFFSET}, 32'(m_off));
    CHAR_VALID = 1'b1;
    CHAR_DATA  = b;
    ATTR_WE    = we;
    ATTR_DATA  = av;
    model_byte(b);
    if (we) m_attr = av;
    @(posedge CLOCK_CORE);
    #1;
    CHAR_VALID = 1'b0;
    ATTR_WE    = 1'b0;
  endtask

  task automatic attr_write(input logic [7:0] av);
    @(negedge CLOCK_CORE);
    ATTR_WE   = 1'b1;
    ATTR_DATA = av;
    m_attr    = av;
    @(posedge CLOCK_CORE);
    #1;
    ATTR_WE = 1'b0;
  endtask

  // Counts cycles with CHAR_READY low starting now; reports whether WR_EN
  // was high in every one of them.
  task automatic count_busy(output int cycles, output bit all_wr);
    cycles = 0;
    all_wr = 1'b1;
    @(negedge CLOCK_CORE);
    while (!CHAR_READY && cycles < 5000) begin
      cycles++;
      if (!WR_EN) all_wr = 1'b0;
      @(negedge CLOCK_CORE);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready"},  {31'd0, CHAR_READY}, 32'd1);
    check_output({tag, "_wr_en"},  {31'd0, WR_EN}, 32'd0);
    check_output({tag, "_addr"},   {19'd0, WR_ADDRESS}, 32'd0);
    check_output({tag, "_wchar"},  {24'd0, WR_CHAR_DATA}, 32'd0);
    check_output({tag, "_wattr"},  {24'd0, WR_ATTR_DATA}, 32'd0);
    check_output({tag, "_offset"}, {24'd0, ROW_OFFSET}, 32'd0);
    check_output({tag, "_col"},    {25'd0, CURSOR_COL}, 32'd0);
    check_output({tag, "_row"},    {26'd0, CURSOR_ROW}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  busy;
    bit  all_wr;
    int  guard;
    logic [7:0] b;

    model_reset();
    #7;
    check_reset_values("reset");
    #15 RESET_N = 1'b1;

    // 'A','B' back to back at (0,0),(0,1).
    apply_stimulus(8'h41, 1'b0, 8'h00);
    apply_stimulus(8'h42, 1'b0, 8'h00);
    // 'C' with coincident attribute load, then 'D' uses the new attribute.
    apply_stimulus(8'h43, 1'b1, 8'h1E);
    apply_stimulus(8'h44, 1'b0, 8'h00);
    attr_write(DEF_ATTR);

    // Walk to the bottom row and wrap a printable line into a scroll.
    apply_stimulus(8'h0D, 1'b0, 8'h00);
    for (int i = 0; i < ROWS - 1; i++) apply_stimulus(8'h0A, 1'b0, 8'h00);
    for (int i = 0; i < COLS; i++) apply_stimulus(8'h58, 1'b0, 8'h00);
    check_output("scroll_offset", {24'd0, ROW_OFFSET}, 32'd1);
    count_busy(busy, all_wr);
    check_output("scroll_busy_cycles", 32'(busy), 32'(COLS));
    check_output("scroll_wr_each_cycle", {31'd0, all_wr}, 32'd1);

    // 64 more LF scrolls: offset wraps, clear row address wraps too.
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(8'h0A, 1'b0, 8'h00);
      if (i == 10) attr_write(8'h2A);
    end

    // BS/CR: from col 5, BS x6 leaves col 0 with no writes.
    apply_stimulus(8'h0D, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) apply_stimulus(8'h61 + 8'(i), 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) apply_stimulus(8'h08, 1'b0, 8'h00);
    apply_stimulus(8'h0D, 1'b0, 8'h00);

    // Randomized traffic mixing printables, CR, LF, BS and attribute loads.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       b = 8'h0D;
      else if (r < 16) b = 8'h0A;
      else if (r < 24) b = 8'h08;
      else             b = 8'($urandom_range(32, 126));
      apply_stimulus(b, ($urandom_range(0, 9) == 0), 8'($urandom));
      if ($urandom_range(0, 19) == 0) attr_write(8'($urandom));
    end

    // Clear screen.
    apply_stimulus(8'h0C, 1'b0, 8'h00);
    count_busy(busy, all_wr);
    check_output("cls_busy_cycles", 32'(busy), 32'(COLS * ROWS));
    check_output("cls_cursor_col", {25'd0, CURSOR_COL}, 32'd0);
    check_output("cls_cursor_row", {26'd0, CURSOR_ROW}, 32'd0);
    apply_stimulus(8'h51, 1'b0, 8'h00);

    // Reset in the middle of a clear.
    apply_stimulus(8'h0C, 1'b0, 8'h00);
    repeat (40) @(negedge CLOCK_CORE);
    @(posedge CLOCK_CORE);
    #3 RESET_N = 1'b0;
    #1;
    check_reset_values("midclr");
    exp_q.delete();
    model_reset();
    #13 RESET_N = 1'b1;
    repeat (10) @(negedge CLOCK_CORE);
    check_output("post_reset_ready", {31'd0, CHAR_READY}, 32'd1);
    apply_stimulus(8'h5A, 1'b0, 8'h00);

    // Drain outstanding writes.
    guard = 0;
    while (exp_q.size() != 0 && guard < 6000) begin
      @(negedge CLOCK_CORE);
      guard++;
    end
    repeat (3) @(negedge CLOCK_CORE);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
